// File: rtl/unit_pack_pkg.sv
// Shared types for the unit packer: FIFO entry layout and the unit-range strobe helper.
// Entry field widths follow the UP_* constants; the top defaults its parameters to them.
package unit_pack_pkg;
  localparam int UP_DATA_WIDTH      = 32;
  localparam int UP_DATA_UNIT       = 8;
  localparam int UP_USER_INFO_WIDTH = 8;
  localparam int UP_UNITS           = UP_DATA_WIDTH / UP_DATA_UNIT;
  localparam int UP_NUM_W           = $clog2(UP_UNITS) + 1;

  typedef struct packed {
    logic [UP_DATA_WIDTH-1:0]      data;
    logic [UP_UNITS-1:0]           strb;
    logic [UP_NUM_W-1:0]           unit_num;
    logic                          done;
    logic                          last;
    logic [UP_USER_INFO_WIDTH-1:0] user_info;
  } entry_t;

  // Strobe bit i set for ofst <= i < end_pos.
  function automatic logic [UP_UNITS-1:0] unit_mask(input logic [UP_NUM_W-1:0] ofst,
                                                    input logic [UP_NUM_W-1:0] end_pos);
    logic [UP_UNITS-1:0] m;
    for (int i = 0; i < UP_UNITS; i++)
      m[i] = (UP_NUM_W'(i) >= ofst) && (UP_NUM_W'(i) < end_pos);
    return m;
  endfunction
endpackage

// File: rtl/unit_pack_fifo_mem.sv
// DEPTH-entry FIFO of packer entries: up to two pushes and one pop per cycle.
// Pointers carry a wrap bit; full/empty come from comparing it.
module unit_pack_fifo_mem
  import unit_pack_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [1:0]   push_n,
  input  entry_t       push0,
  input  entry_t       push1,
  input  logic         pop,
  output entry_t       head,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);
  entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt;

  assign wr_nxt = wr_ptr + (AW+1)'(1);

  always_ff @(posedge clk) begin
    if (!clr && push_n != 2'd0) mem[wr_ptr[AW-1:0]] <= push0;
    if (!clr && push_n == 2'd2) mem[wr_nxt[AW-1:0]] <= push1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push_n);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/unit_pack_fifo.sv
// Packs unit-granular source beats into strobed words and queues them for the consumer.
// Define UNIT_PACK_FIFO_OCC_EN to expose the FIFO occupancy on dst_count.
module unit_pack_fifo
  import unit_pack_pkg::*;
#(
  parameter int DATA_WIDTH      = UP_DATA_WIDTH,
  parameter int DATA_UNIT       = UP_DATA_UNIT,
  parameter int USER_INFO_WIDTH = UP_USER_INFO_WIDTH,
  parameter int DEPTH           = 4,
  localparam int UNITS  = DATA_WIDTH / DATA_UNIT,
  localparam int OFST_W = $clog2(UNITS),
  localparam int NUM_W  = OFST_W + 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic [DATA_WIDTH-1:0]      src_data,
  input  logic [OFST_W-1:0]          src_offset,
  input  logic [NUM_W-1:0]           src_unit_num,
  input  logic                       src_bgin,
  input  logic [OFST_W-1:0]          src_initial_offset,
  input  logic                       src_done,
  input  logic                       src_last,
  input  logic [USER_INFO_WIDTH-1:0] src_user_info,
  output logic                       dst_valid,
  input  logic                       dst_ready,
  output logic [DATA_WIDTH-1:0]      dst_data,
  output logic [UNITS-1:0]           dst_strb,
  output logic [NUM_W-1:0]           dst_unit_num,
  output logic                       dst_done,
  output logic                       dst_last,
  output logic [USER_INFO_WIDTH-1:0] dst_user_info,
  output logic                       pack_err
`ifdef UNIT_PACK_FIFO_OCC_EN
  ,
  output logic [CNT_W-1:0]           dst_count
`endif
);
  localparam int TOT_W = NUM_W + 1;

  entry_t head, push0, push1, ent_err, ent_w0, ent_w1, spill;
  logic [1:0] push_n, k;
  logic [CNT_W-1:0] count;
  logic empty, full, pop, accept, spill_vld, spill_push;

  logic                       acc_open;
  logic [DATA_WIDTH-1:0]      acc_data, d0, shifted, dmask;
  logic [OFST_W-1:0]          acc_fill, acc_ofst, p, o, rem;
  logic [USER_INFO_WIDTH-1:0] acc_user, u;
  logic [NUM_W-1:0]           n;
  logic [TOT_W-1:0]           total;
  logic [2*DATA_WIDTH-1:0]    comb2;
  logic                       is_full, pe, p0, p1;

  // A third entry (bgin-while-open plus split done beat) parks in spill; the source stalls until it drains.
  assign src_ready  = !spill_vld && (count <= CNT_W'(DEPTH - 2));
  assign accept     = src_valid && src_ready && !flush;
  assign pop        = !empty && dst_ready && !flush;
  assign spill_push = spill_vld && !full;

  always_comb begin
    n       = (src_unit_num > NUM_W'(UNITS)) ? NUM_W'(UNITS) : src_unit_num;
    shifted = src_data >> (DATA_UNIT * int'(src_offset));
    for (int i = 0; i < UNITS; i++)
      dmask[i*DATA_UNIT +: DATA_UNIT] = {DATA_UNIT{NUM_W'(i) < n}};
    p       = src_bgin ? src_initial_offset : acc_fill;
    o       = src_bgin ? src_initial_offset : acc_ofst;
    u       = src_bgin ? src_user_info : acc_user;
    d0      = src_bgin ? '0 : acc_data;
    comb2   = {{DATA_WIDTH{1'b0}}, d0}
            | ({{DATA_WIDTH{1'b0}}, shifted & dmask} << (DATA_UNIT * int'(p)));
    total   = TOT_W'(p) + TOT_W'(n);
    is_full = total >= TOT_W'(UNITS);
    rem     = OFST_W'(total - TOT_W'(UNITS));
    pe      = src_bgin && acc_open;
    p0      = is_full || src_done;
    p1      = is_full && src_done && (rem != '0);

    ent_err = '{data: acc_data, strb: unit_mask(NUM_W'(acc_ofst), NUM_W'(acc_fill)),
                unit_num: NUM_W'(acc_fill), done: 1'b1, last: 1'b0, user_info: acc_user};

    ent_w0.data      = comb2[DATA_WIDTH-1:0];
    ent_w0.user_info = u;
    if (is_full) begin
      ent_w0.strb     = unit_mask(NUM_W'(o), NUM_W'(UNITS));
      ent_w0.unit_num = NUM_W'(UNITS);
      ent_w0.done     = src_done && (rem == '0);
      ent_w0.last     = src_done && (rem == '0) && src_last;
    end else begin
      ent_w0.strb     = unit_mask(NUM_W'(o), NUM_W'(total));
      ent_w0.unit_num = NUM_W'(total);
      ent_w0.done     = 1'b1;
      ent_w0.last     = src_last;
    end

    ent_w1 = '{data: comb2[2*DATA_WIDTH-1:DATA_WIDTH], strb: unit_mask('0, NUM_W'(rem)),
               unit_num: NUM_W'(rem), done: 1'b1, last: src_last, user_info: u};

    k      = 2'(pe) + 2'(p0) + 2'(p1);
    push_n = 2'd0;
    push0  = ent_w0;
    push1  = ent_w1;
    if (spill_push) begin
      push_n = 2'd1;
      push0  = spill;
    end else if (accept) begin
      push0  = pe ? ent_err : ent_w0;
      push1  = pe ? ent_w0 : ent_w1;
      push_n = (k == 2'd3) ? 2'd2 : k;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      acc_open  <= 1'b0;
      acc_data  <= '0;
      acc_fill  <= '0;
      acc_ofst  <= '0;
      acc_user  <= '0;
      spill_vld <= 1'b0;
      spill     <= '0;
      pack_err  <= 1'b0;
    end else begin
      pack_err <= accept && pe;
      if (spill_push) spill_vld <= 1'b0;
      if (accept) begin
        acc_user <= u;
        if (k == 2'd3) begin
          spill_vld <= 1'b1;
          spill     <= ent_w1;
        end
        if (src_done) begin
          acc_open <= 1'b0;
          acc_data <= '0;
          acc_fill <= '0;
          acc_ofst <= '0;
        end else if (is_full) begin
          acc_open <= 1'b1;
          acc_data <= comb2[2*DATA_WIDTH-1:DATA_WIDTH];
          acc_fill <= rem;
          acc_ofst <= '0;
        end else begin
          acc_open <= 1'b1;
          acc_data <= comb2[DATA_WIDTH-1:0];
          acc_fill <= OFST_W'(total);
          acc_ofst <= o;
        end
      end
    end
  end

  unit_pack_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .clr    (rst || flush),
    .push_n (push_n),
    .push0  (push0),
    .push1  (push1),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .empty  (empty),
    .full   (full)
  );

  // Zero the head fields when empty so stale storage never shows on dst.
  assign dst_valid     = !empty;
  assign dst_data      = empty ? '0 : head.data;
  assign dst_strb      = empty ? '0 : head.strb;
  assign dst_unit_num  = empty ? '0 : head.unit_num;
  assign dst_done      = !empty && head.done;
  assign dst_last      = !empty && head.last;
  assign dst_user_info = empty ? '0 : head.user_info;
`ifdef UNIT_PACK_FIFO_OCC_EN
  assign dst_count     = count;
`endif
endmodule
